// File: rtl/cond_pkg.sv
// Shared ARM condition-code encodings and NZCV flag bit positions for the
// conditional-execution stage.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Evaluates a 4-bit ARM condition field against the architectural NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v, ge;

    assign n  = Flags[FLAG_N];
    assign z  = Flags[FLAG_Z];
    assign c  = Flags[FLAG_C];
    assign v  = Flags[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~z & ge;
            COND_LE: CondEx = z | ~ge;
            COND_AL: CondEx = 1'b1;
            // 1111 is unsupported and must squash the instruction
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module flopenr #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= RESET_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/flopr.sv
// Plain register with synchronous active-high reset to a parameterised value.
module flopr #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= RESET_VAL;
        else       q <= d;
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, checks Cond, and gates the decoder's
// write requests using the condition result registered one cycle earlier.
module cond_logic
    import cond_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       NextPC,
    input  logic       RegW,
    input  logic       MemW,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] Flags,
    output logic       CondEx
);

    logic [1:0] flagwrite;
    logic [1:0] nz, cv;
    logic       condexdelayed;
    logic       gate;

    cond_check u_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (CondEx)
    );

    assign flagwrite = FlagW & {2{CondEx}};

    flopenr #(.WIDTH(2), .RESET_VAL(RESET_FLAGS[FLAG_N:FLAG_Z])) u_flag_nz (
        .clk   (clk),
        .reset (reset),
        .en    (flagwrite[1]),
        .d     (ALUFlags[FLAG_N:FLAG_Z]),
        .q     (nz)
    );

    flopenr #(.WIDTH(2), .RESET_VAL(RESET_FLAGS[FLAG_C:FLAG_V])) u_flag_cv (
        .clk   (clk),
        .reset (reset),
        .en    (flagwrite[0]),
        .d     (ALUFlags[FLAG_C:FLAG_V]),
        .q     (cv)
    );

    assign Flags = {nz, cv};

    flopr #(.WIDTH(1), .RESET_VAL(1'b0)) u_condex_q (
        .clk   (clk),
        .reset (reset),
        .d     (CondEx),
        .q     (condexdelayed)
    );

    // Writebacks are suppressed while reset is held, before the flop has cleared
    assign gate     = condexdelayed & ~reset;
    assign PCWrite  = (PCS & gate) | NextPC;
    assign RegWrite = RegW & gate;
    assign MemWrite = MemW & gate;

endmodule
